// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register file write port among NREQ writeback requesters,
// with a one-deep registered output stage and a pending-write mask for hazard detection.
module regfile_wr_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int WAW  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*AW-1:0]       req_addr,
  input  logic [NREQ*DW-1:0]       req_data,
  input  logic                     stall,
  output logic                     we3,
  output logic [WAW-1:0]           wa3,
  output logic [DW-1:0]            wd3,
  output logic [$clog2(NREQ)-1:0]  wr_src,
  output logic [31:0]              pend_mask
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]     r_rr_ptr;
  logic              r_we3;
  logic [WAW-1:0]    r_wa3;
  logic [DW-1:0]     r_wd3;
  logic [PW-1:0]     r_wr_src;
  logic [31:0]       r_pend;

  logic [2*NREQ-1:0] w_rot;
  logic              w_found;
  logic [PW-1:0]     w_gnt_idx;
  logic [PW:0]       w_sum;
  logic              w_xfer;
  logic [AW-1:0]     w_addr;
  logic [DW-1:0]     w_data;

  // Rotating the doubled valid vector puts the current priority holder at bit 0.
  assign w_rot = {req_valid, req_valid} >> r_rr_ptr;

  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found   = 1'b1;
        w_sum     = {1'b0, r_rr_ptr} + (PW+1)'(k);
        w_gnt_idx = (w_sum >= (PW+1)'(NREQ)) ? PW'(w_sum - (PW+1)'(NREQ)) : PW'(w_sum);
      end
    end
  end

  assign w_xfer    = w_found & ~stall & rst_n;
  assign req_ready = w_xfer ? (NREQ'(1) << w_gnt_idx) : '0;

  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_gnt_idx == PW'(j)) begin
        w_addr = req_addr[j*AW +: AW];
        w_data = req_data[j*DW +: DW];
      end
    end
  end

  // A pending bit only lives for the single cycle between grant and commit, so it simply
  // tracks the most recent grant; a same-edge regrant of that register keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_we3    <= 1'b0;
      r_wa3    <= '0;
      r_wd3    <= '0;
      r_wr_src <= '0;
      r_pend   <= '0;
    end else if (w_xfer) begin
      r_rr_ptr <= (w_gnt_idx == PW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;
      r_we3    <= |w_addr;
      r_wa3    <= WAW'(w_addr);
      r_wd3    <= w_data;
      r_wr_src <= w_gnt_idx;
      r_pend   <= (|w_addr) ? (32'd1 << w_addr) : 32'd0;
    end else begin
      r_we3    <= 1'b0;
      r_pend   <= '0;
    end
  end

  assign we3       = r_we3;
  assign wa3       = r_wa3;
  assign wd3       = r_wd3;
  assign wr_src    = r_wr_src;
  assign pend_mask = r_pend;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios plus a randomized run
// checked against a round-robin reference model.
module tb_regfile_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        stall;
  logic        we3;
  logic [31:0] wa3;
  logic [31:0] wd3;
  logic [1:0]  wr_src;
  logic [31:0] pend_mask;

  int total = 0;
  int bad   = 0;

  logic [31:0] rf [32];

  int          m_ptr;
  logic        m_we3;
  logic [31:0] m_wa3;
  logic [31:0] m_wd3;
  int          m_src;
  logic [31:0] m_pend;

  regfile_wr_arbiter #(.NREQ(3), .DW(32), .AW(5), .WAW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .stall     (stall),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .wr_src    (wr_src),
    .pend_mask (pend_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file image built from the committed write port.
  always @(posedge clk) begin
    if (we3) rf[wa3[4:0]] <= wd3;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i]       = v;
    req_addr[i*5 +: 5] = a;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    stall     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference arbiter: first valid index scanning upward from the pointer, wrapping.
  function automatic int m_winner();
    int idx;
    for (int k = 0; k < 3; k++) begin
      idx = (m_ptr + k) % 3;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 3'($urandom());
    req_addr  = 15'($urandom());
    req_data  = {$urandom(), $urandom(), $urandom()};
    stall     = 1'($urandom());
    #2;
    total += 3;
    if (req_ready !== 3'b000) begin bad++; $display("[TB] FAIL rst_ready: got %b expected 000", req_ready); end
    if (we3 !== 1'b0) begin bad++; $display("[TB] FAIL rst_we3: got %b expected 0", we3); end
    if (pend_mask !== 32'd0) begin bad++; $display("[TB] FAIL rst_pend: got %h expected 0", pend_mask); end
    @(posedge clk);
    req_valid = 3'b111;
    stall     = 1'b0;
    @(negedge clk);
    #1;
    total += 5;
    if (req_ready !== 3'b000) begin bad++; $display("[TB] FAIL rst_ready_clk: got %b expected 000", req_ready); end
    if (we3 !== 1'b0) begin bad++; $display("[TB] FAIL rst_we3_clk: got %b expected 0", we3); end
    if (wa3 !== 32'd0) begin bad++; $display("[TB] FAIL rst_wa3: got %h expected 0", wa3); end
    if (wd3 !== 32'd0) begin bad++; $display("[TB] FAIL rst_wd3: got %h expected 0", wd3); end
    if (wr_src !== 2'd0) begin bad++; $display("[TB] FAIL rst_src: got %0d expected 0", wr_src); end
    rst_n     = 1'b1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    total += 3;
    if (we3 !== 1'b0) begin bad++; $display("[TB] FAIL idle_we3: got %b expected 0", we3); end
    if (pend_mask !== 32'd0) begin bad++; $display("[TB] FAIL idle_pend: got %h expected 0", pend_mask); end
    if (wd3 !== 32'd0) begin bad++; $display("[TB] FAIL idle_wd3: got %h expected 0", wd3); end
    req_valid = 3'b111;
    #1;
    total++;
    if (req_ready !== 3'b001) begin bad++; $display("[TB] FAIL idle_ptr: got %b expected 001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    set_req(1, 1'b1, 5'd7, 32'hDEADBEEF);
    #1;
    total++;
    if (req_ready !== 3'b010) begin bad++; $display("[TB] FAIL single_ready: got %b expected 010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    total += 5;
    if (we3 !== 1'b1) begin bad++; $display("[TB] FAIL single_we3: got %b expected 1", we3); end
    if (wa3 !== 32'd7) begin bad++; $display("[TB] FAIL single_wa3: got %h expected 7", wa3); end
    if (wd3 !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL single_wd3: got %h expected deadbeef", wd3); end
    if (wr_src !== 2'd1) begin bad++; $display("[TB] FAIL single_src: got %0d expected 1", wr_src); end
    if (pend_mask !== 32'h80) begin bad++; $display("[TB] FAIL single_pend: got %h expected 80", pend_mask); end
    @(negedge clk);
    #1;
    total += 3;
    if (pend_mask !== 32'd0) begin bad++; $display("[TB] FAIL single_pend_clr: got %h expected 0", pend_mask); end
    if (we3 !== 1'b0) begin bad++; $display("[TB] FAIL single_we3_off: got %b expected 0", we3); end
    if (wa3 !== 32'd7) begin bad++; $display("[TB] FAIL single_wa3_hold: got %h expected 7", wa3); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 5'(10 + i), 32'(100 + i));
    for (int c = 0; c < 6; c++) begin
      #1;
      total++;
      if (req_ready !== 3'(1 << (c % 3))) begin
        bad++; $display("[TB] FAIL rr_ready%0d: got %b expected %b", c, req_ready, 3'(1 << (c % 3)));
      end
      if (c > 0) begin
        total += 2;
        if (we3 !== 1'b1) begin bad++; $display("[TB] FAIL rr_we3_%0d: got %b expected 1", c, we3); end
        if (wr_src !== 2'((c - 1) % 3)) begin
          bad++; $display("[TB] FAIL rr_src%0d: got %0d expected %0d", c, wr_src, (c - 1) % 3);
        end
      end
      @(negedge clk);
    end
    req_valid = '0;
    #1;
    total += 2;
    if (wr_src !== 2'd2) begin bad++; $display("[TB] FAIL rr_src_last: got %0d expected 2", wr_src); end
    if (wd3 !== 32'd102) begin bad++; $display("[TB] FAIL rr_wd3_last: got %0d expected 102", wd3); end
  endtask

  task automatic test_x0();
    do_reset();
    set_req(0, 1'b1, 5'd0, 32'd5);
    #1;
    total++;
    if (req_ready !== 3'b001) begin bad++; $display("[TB] FAIL x0_ready: got %b expected 001", req_ready); end
    @(negedge clk);
    set_req(0, 1'b1, 5'd1, 32'd0);
    req_valid = 3'b111;
    #1;
    total += 5;
    if (req_ready !== 3'b010) begin bad++; $display("[TB] FAIL x0_ptr: got %b expected 010", req_ready); end
    if (we3 !== 1'b0) begin bad++; $display("[TB] FAIL x0_we3: got %b expected 0", we3); end
    if (pend_mask !== 32'd0) begin bad++; $display("[TB] FAIL x0_pend: got %h expected 0", pend_mask); end
    if (wd3 !== 32'd5) begin bad++; $display("[TB] FAIL x0_wd3: got %h expected 5", wd3); end
    if (wa3 !== 32'd0) begin bad++; $display("[TB] FAIL x0_wa3: got %h expected 0", wa3); end
    req_valid = '0;
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 5'(i + 1), 32'(i + 40));
    #1;
    total++;
    if (req_ready !== 3'b001) begin bad++; $display("[TB] FAIL stall_pre: got %b expected 001", req_ready); end
    @(negedge clk);
    stall = 1'b1;
    #1;
    total += 3;
    if (req_ready !== 3'b000) begin bad++; $display("[TB] FAIL stall_ready0: got %b expected 000", req_ready); end
    if (we3 !== 1'b1) begin bad++; $display("[TB] FAIL stall_inflight: got %b expected 1", we3); end
    if (wr_src !== 2'd0) begin bad++; $display("[TB] FAIL stall_src: got %0d expected 0", wr_src); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      total += 3;
      if (req_ready !== 3'b000) begin bad++; $display("[TB] FAIL stall_ready%0d: got %b expected 000", c + 1, req_ready); end
      if (we3 !== 1'b0) begin bad++; $display("[TB] FAIL stall_we3_%0d: got %b expected 0", c + 1, we3); end
      if (pend_mask !== 32'd0) begin bad++; $display("[TB] FAIL stall_pend%0d: got %h expected 0", c + 1, pend_mask); end
    end
    @(negedge clk);
    stall = 1'b0;
    #1;
    total++;
    if (req_ready !== 3'b010) begin bad++; $display("[TB] FAIL stall_release: got %b expected 010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    total += 2;
    if (we3 !== 1'b1) begin bad++; $display("[TB] FAIL stall_post_we3: got %b expected 1", we3); end
    if (wd3 !== 32'd41) begin bad++; $display("[TB] FAIL stall_post_wd3: got %0d expected 41", wd3); end
  endtask

  task automatic test_same_reg();
    do_reset();
    set_req(0, 1'b1, 5'd9, 32'd1);
    #1;
    total++;
    if (req_ready !== 3'b001) begin bad++; $display("[TB] FAIL same_ready0: got %b expected 001", req_ready); end
    @(negedge clk);
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 5'd9, 32'd2);
    #1;
    total += 4;
    if (req_ready !== 3'b010) begin bad++; $display("[TB] FAIL same_ready1: got %b expected 010", req_ready); end
    if (we3 !== 1'b1) begin bad++; $display("[TB] FAIL same_we3_a: got %b expected 1", we3); end
    if (wd3 !== 32'd1) begin bad++; $display("[TB] FAIL same_wd3_a: got %0d expected 1", wd3); end
    if (pend_mask !== 32'h200) begin bad++; $display("[TB] FAIL same_pend_a: got %h expected 200", pend_mask); end
    @(negedge clk);
    req_valid = '0;
    #1;
    total += 3;
    if (wd3 !== 32'd2) begin bad++; $display("[TB] FAIL same_wd3_b: got %0d expected 2", wd3); end
    if (wr_src !== 2'd1) begin bad++; $display("[TB] FAIL same_src_b: got %0d expected 1", wr_src); end
    if (pend_mask !== 32'h200) begin bad++; $display("[TB] FAIL same_pend_b: got %h expected 200", pend_mask); end
    @(negedge clk);
    #1;
    total += 2;
    if (rf[9] !== 32'd2) begin bad++; $display("[TB] FAIL same_rf9: got %0d expected 2", rf[9]); end
    if (pend_mask !== 32'd0) begin bad++; $display("[TB] FAIL same_pend_c: got %h expected 0", pend_mask); end
    set_req(2, 1'b1, 5'd9, 32'd3);
    @(negedge clk);
    req_valid = '0;
    #1;
    total++;
    if (we3 !== 1'b1) begin bad++; $display("[TB] FAIL midrst_pre: got %b expected 1", we3); end
    rst_n = 1'b0;
    #1;
    total += 3;
    if (we3 !== 1'b0) begin bad++; $display("[TB] FAIL midrst_we3: got %b expected 0", we3); end
    if (pend_mask !== 32'd0) begin bad++; $display("[TB] FAIL midrst_pend: got %h expected 0", pend_mask); end
    if (wd3 !== 32'd0) begin bad++; $display("[TB] FAIL midrst_wd3: got %h expected 0", wd3); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int          g;
    int          w;
    logic [2:0]  exp_ready;
    logic [4:0]  a;
    do_reset();
    m_ptr = 0; m_we3 = 1'b0; m_wa3 = '0; m_wd3 = '0; m_src = 0; m_pend = '0;
    g = -1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] || g == i) begin
          a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
          set_req(i, ($urandom_range(0, 2) != 0), a, $urandom());
        end
      end
      stall = ($urandom_range(0, 3) == 0);
      #1;
      w = m_winner();
      exp_ready = (stall || w < 0) ? 3'b000 : 3'(1 << w);
      total += 6;
      if (req_ready !== exp_ready) begin bad++; $display("[TB] FAIL rnd_ready@%0d: got %b expected %b", c, req_ready, exp_ready); end
      if (we3 !== m_we3) begin bad++; $display("[TB] FAIL rnd_we3@%0d: got %b expected %b", c, we3, m_we3); end
      if (wa3 !== m_wa3) begin bad++; $display("[TB] FAIL rnd_wa3@%0d: got %h expected %h", c, wa3, m_wa3); end
      if (wd3 !== m_wd3) begin bad++; $display("[TB] FAIL rnd_wd3@%0d: got %h expected %h", c, wd3, m_wd3); end
      if (wr_src !== 2'(m_src)) begin bad++; $display("[TB] FAIL rnd_src@%0d: got %0d expected %0d", c, wr_src, m_src); end
      if (pend_mask !== m_pend) begin bad++; $display("[TB] FAIL rnd_pend@%0d: got %h expected %h", c, pend_mask, m_pend); end
      @(posedge clk);
      g = (!stall && w >= 0) ? w : -1;
      if (g >= 0) begin
        a      = req_addr[g*5 +: 5];
        m_we3  = (a != 5'd0);
        m_wa3  = 32'(a);
        m_wd3  = req_data[g*32 +: 32];
        m_src  = g;
        m_pend = (a != 5'd0) ? (32'd1 << a) : 32'd0;
        m_ptr  = (g + 1) % 3;
      end else begin
        m_we3  = 1'b0;
        m_pend = '0;
      end
      @(negedge clk);
    end
    req_valid = '0;
    stall     = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    stall     = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_x0();
    test_stall();
    test_same_reg();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Shares the single synchronous write port (we3/wa3/wd3) of the 32-entry register file between NREQ writeback requesters, such as the ALU, the load unit and the CSR/debug path.
Arbitration is round-robin, and each requester uses a valid/ready handshake.
The selected write is registered into a one-deep output stage that drives the register file directly.
The block also keeps a pending-write mask so that issue logic can detect read-after-write hazards on in-flight writes.

Parameters:
NREQ, 3, number of write requesters (2..8)
DW, 32, write data width
AW, 5, register index width carried on requester ports
WAW, 32, width of the wa3 output (zero-extended from AW to match the register file port)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  requester i has a write pending
req_ready  out  NREQ  requester i is granted this cycle (combinational)
req_addr  in  NREQ*AW  flattened destination index; slice i = [i*AW +: AW]
req_data  in  NREQ*DW  flattened write data; slice i = [i*DW +: DW]
stall  in  1  blocks new grants for the current cycle
we3  out  1  register file write enable (registered)
wa3  out  WAW  register file write address (registered, zero-extended)
wd3  out  DW  register file write data (registered)
wr_src  out  $clog2(NREQ)  index of the requester that owns the current we3 write (registered)
pend_mask  out  32  bit r = 1 while a write to register r is granted but not yet committed

Behaviour:
- Reset (async assert, sync release):
  - rr_ptr = 0, we3 = 0, wa3 = 0, wd3 = 0, wr_src = 0, pend_mask = 0.
  - req_ready = 0 while rst_n = 0.
- Arbitration, combinational in cycle t:
  - Priority order is rr_ptr, rr_ptr+1, ..., wrapping mod NREQ.
  - Winner = the first index in that order with req_valid set.
  - req_ready is one-hot to the winner, and only when stall = 0.
  - All req_ready bits are 0 when stall = 1 or no req_valid bit is set.
- Handshake:
  - A transfer occurs when req_valid[i] & req_ready[i] are both high at a rising edge.
  - Requesters hold addr and data stable while valid and not ready; valid must not drop before ready.
  - req_ready may depend combinationally on req_valid. No requester's valid may depend on its own ready.
- Pointer update:
  - On a transfer from index i, rr_ptr <= (i+1) mod NREQ. This wraps from NREQ-1 to 0.
  - With no transfer, rr_ptr holds.
- Output stage, 1-cycle latency (a grant at edge t drives the outputs for cycle t+1):
  - we3 = 1 iff the granted addr != 0.
  - wa3 = {zeros, addr}.
  - wd3 = data.
  - wr_src = i.
- No transfer at edge t: at t+1, we3 = 0. wa3, wd3 and wr_src hold their previous values.
- Writes to x0: the request is accepted (ready = 1, pointer advances), but we3 = 0 at t+1. wa3 and wd3 still load.
- Back-to-back transfers are legal every cycle. The output stage never backpressures; stall is the only throttle.
- stall:
  - Only suppresses new grants.
  - A write already in the output stage commits regardless of stall.
- pend_mask:
  - Set: bit a sets at the grant edge for addr a, for a != 0.
  - Clear: the bit clears at the following edge, when we3/wa3 commit.
  - Same-edge clear and new grant to the same a: set wins, so the bit stays 1.
  - Bit 0 is constantly 0.
- Same-register ordering: two requesters targeting the same register are committed in grant order, so the last granted write wins.
- Reset mid-operation: an in-flight registered write is discarded (we3 = 0 immediately) and pend_mask clears asynchronously.
- req_addr bits beyond AW do not exist. Index width is fixed at AW; no range check is needed for AW = 5.

Test Plan:
1. Reset then idle: rst_n low with all inputs random -> we3 = 0, pend_mask = 0, req_ready = 0. After release with req_valid = 0 -> outputs stay 0 and rr_ptr stays 0.
2. Single requester: req_valid = 3'b010, addr = 7, data = 32'hDEADBEEF at cycle t.
   - Cycle t: req_ready = 3'b010.
   - Cycle t+1: we3 = 1, wa3 = 7, wd3 = 32'hDEADBEEF, wr_src = 1, pend_mask[7] = 1.
   - Cycle t+2: pend_mask[7] = 0.
3. Round-robin fairness: all three valid continuously for 6 cycles -> grants 0,1,2,0,1,2, one per cycle, with we3 = 1 every cycle from t+1.
4. x0 write: req 0 valid, addr = 0, data = 5 -> req_ready[0] = 1 and rr_ptr becomes 1. Next cycle we3 = 0 and pend_mask = 0.
5. Stall: all valid with stall = 1 for 3 cycles -> req_ready = 0 and we3 = 0 after the in-flight write commits. On stall release, the grant goes to the stored rr_ptr.
6. Same-register back-to-back: req 0 then req 1 both to addr 9 (data 1, then 2) on consecutive grants.
   - pend_mask[9] stays 1 across both grants.
   - Commits appear in order: wd3 = 1, then wd3 = 2.
   - The register file ends with x9 = 2.
   - Asserting rst_n = 0 mid-sequence clears we3 and pend_mask immediately.
